mem_io_responder: RTL

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped TX/RX byte FIFOs behind one bus port.
// Optional RX FIFO is built only when MEMIO_RX_FIFO_EN is defined.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_wr,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        io_full
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef MEMIO_RX_FIFO_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic [7:0] ram [0:(1<<RAM_ADDR_WIDTH)-1];
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;

  logic        is_io;
  logic        io_data;
  logic        io_stat;
  logic        bus_wr;
  logic        bus_rd;
  logic        new_addr;
  logic [31:0] prev_a;

  logic [7:0]  tx_mem [0:DEPTH-1];
  logic [AW:0] tx_wp;
  logic [AW:0] tx_rp;
  logic        tx_pop;
  logic        tx_push;
  logic        tx_ovf;
  logic        ovf_set;
  logic        ovf_clr;

  logic        rx_empty;
  logic [7:0]  rx_head;
  logic [7:0]  status;
  logic [7:0]  rd_data;
  logic        rd_load;

  assign ram_idx  = mem_a[RAM_ADDR_WIDTH-1:0];
  assign is_io    = mem_a[17:16] == 2'b11;
  assign io_data  = is_io && (mem_a[17:0] == 18'h30000);
  assign io_stat  = is_io && (mem_a[17:0] == 18'h30004);
  assign bus_wr   = rdy_in && mem_wr;
  assign bus_rd   = rdy_in && !mem_wr;
  assign new_addr = mem_a != prev_a;

  assign tx_valid = tx_wp != tx_rp;
  assign io_full  = (tx_wp[AW] != tx_rp[AW]) &&
                    (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_data  = tx_mem[tx_rp[AW-1:0]];
  assign tx_pop   = tx_valid && tx_ready;
  // A pop in the same edge frees the slot a full FIFO is being asked for
  assign tx_push  = bus_wr && io_data && (!io_full || tx_pop);
  assign ovf_set  = bus_wr && io_data && io_full && !tx_pop;
  assign ovf_clr  = bus_wr && io_stat && mem_din[2];

`ifdef MEMIO_RX_FIFO_EN
  logic [7:0]  rx_mem [0:DEPTH-1];
  logic [AW:0] rx_wp;
  logic [AW:0] rx_rp;
  logic        rx_full;
  logic        rx_push;
  logic        rx_pop;

  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                    (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];
  assign rx_push  = rx_valid && !rx_full;
  // Only a freshly presented address consumes a byte
  assign rx_pop   = bus_rd && io_data && new_addr && !rx_empty;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_data;
  end
`else
  logic unused_rx;
  assign unused_rx = ^{rx_valid, rx_data};
  assign rx_empty  = 1'b1;
  assign rx_head   = 8'h00;
`endif

  assign status = {5'b0, tx_ovf, rx_empty, io_full};

  always_comb begin
    rd_data = 8'h00;
    rd_load = 1'b1;
    if (!is_io) begin
      rd_data = ram[ram_idx];
    end else if (io_data) begin
      rd_load = new_addr || !RX_EN;
      rd_data = rx_empty ? 8'h00 : rx_head;
    end else if (io_stat) begin
      rd_data = status;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_dout <= 8'h00;
      prev_a   <= 32'hFFFF_FFFF;
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      if (bus_rd && rd_load) mem_dout <= rd_data;
      if (rdy_in) prev_a <= mem_a;
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (ovf_set)      tx_ovf <= 1'b1;
      else if (ovf_clr) tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (bus_wr && !is_io) ram[ram_idx] <= mem_din;
  end

endmodule
